// File: rtl/fp_mul_issuer_if.sv
// Signal bundle between the FP multiply issuer and its neighbours: issue stage,
// strobe/ack multiplier operand port and writeback. master = issuer side.
interface fp_mul_issuer_if #(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic [TAG_W-1:0]  req_tag;

    logic [31:0]       mul_in_A;
    logic              mul_strb_A;
    logic              mul_in_A_ack;
    logic [31:0]       mul_in_B;
    logic              mul_strb_B;
    logic              mul_in_B_ack;
    logic [31:0]       mul_prod;
    logic              mul_prod_stb;
    logic              mul_prod_ack;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_timeout;
    logic [CNT_W-1:0]  rsp_cycles;

    logic              busy;

    modport master (
        input  req_valid, req_a, req_b, req_tag,
        output req_ready,
        output mul_in_A, mul_strb_A, mul_in_B, mul_strb_B, mul_prod_ack,
        input  mul_in_A_ack, mul_in_B_ack, mul_prod, mul_prod_stb,
        output rsp_valid, rsp_data, rsp_tag, rsp_timeout, rsp_cycles,
        input  rsp_ready,
        output busy
    );

    modport slave (
        output req_valid, req_a, req_b, req_tag,
        input  req_ready,
        input  mul_in_A, mul_strb_A, mul_in_B, mul_strb_B, mul_prod_ack,
        output mul_in_A_ack, mul_in_B_ack, mul_prod, mul_prod_stb,
        input  rsp_valid, rsp_data, rsp_tag, rsp_timeout, rsp_cycles,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/fp_mul_issuer.sv
// Single-outstanding FP multiply front end: strobe/ack operand delivery,
// 4-phase product acknowledge, timeout and latency reporting to writeback.
module fp_mul_issuer #(
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    fp_mul_issuer_if.master bus
);
    localparam int          DWELL_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_ACK, S_RESP} state_t;

    state_t             state, state_next;
    logic [31:0]        in_a_q, in_b_q, data_q;
    logic               strb_a_q, strb_b_q, prod_ack_q, timeout_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q, cycles_q, cnt_inc;
    logic [DWELL_W-1:0] dwell_q;
    logic               a_done, b_done, dwell_expired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next       = state;
        cnt_inc          = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        a_done           = !strb_a_q || bus.mul_in_A_ack;
        b_done           = !strb_b_q || bus.mul_in_B_ack;
        dwell_expired    = (dwell_q == DWELL_W'(TIMEOUT_CYC - 1));

        unique case (state)
            S_IDLE: if (bus.req_valid)         state_next = S_SEND;
            S_SEND: if (a_done && b_done)      state_next = S_WAIT;
            S_WAIT: begin
                // timeout takes priority over a product arriving in the same cycle
                if (dwell_expired)             state_next = S_RESP;
                else if (bus.mul_prod_stb)     state_next = S_ACK;
            end
            S_ACK:  if (!bus.mul_prod_stb)     state_next = S_RESP;
            S_RESP: if (bus.rsp_ready)         state_next = S_IDLE;
            default:                           state_next = S_IDLE;
        endcase

        bus.req_ready    = (state == S_IDLE);
        bus.busy         = (state != S_IDLE);
        bus.rsp_valid    = (state == S_RESP);
        bus.mul_in_A     = in_a_q;
        bus.mul_in_B     = in_b_q;
        bus.mul_strb_A   = strb_a_q;
        bus.mul_strb_B   = strb_b_q;
        bus.mul_prod_ack = prod_ack_q;
        bus.rsp_data     = data_q;
        bus.rsp_tag      = tag_q;
        bus.rsp_timeout  = timeout_q;
        bus.rsp_cycles   = cycles_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_a_q     <= '0;
            in_b_q     <= '0;
            data_q     <= '0;
            tag_q      <= '0;
            strb_a_q   <= 1'b0;
            strb_b_q   <= 1'b0;
            prod_ack_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            cycles_q   <= '0;
            dwell_q    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        in_a_q   <= bus.req_a;
                        in_b_q   <= bus.req_b;
                        tag_q    <= bus.req_tag;
                        strb_a_q <= 1'b1;
                        strb_b_q <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                S_SEND: begin
                    cnt_q   <= cnt_inc;
                    dwell_q <= '0;
                    if (strb_a_q && bus.mul_in_A_ack) strb_a_q <= 1'b0;
                    if (strb_b_q && bus.mul_in_B_ack) strb_b_q <= 1'b0;
                end
                S_WAIT: begin
                    cnt_q   <= cnt_inc;
                    dwell_q <= dwell_q + DWELL_W'(1);
                    if (dwell_expired) begin
                        data_q    <= QNAN;
                        timeout_q <= 1'b1;
                        cycles_q  <= cnt_inc;
                    end else if (bus.mul_prod_stb) begin
                        data_q     <= bus.mul_prod;
                        prod_ack_q <= 1'b1;
                    end
                end
                S_ACK: begin
                    cnt_q <= cnt_inc;
                    if (!bus.mul_prod_stb) begin
                        prod_ack_q <= 1'b0;
                        cycles_q   <= cnt_inc;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) timeout_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_issuer.sv
// Randomised and directed bench for fp_mul_issuer against a protocol-level
// model of one in-flight multiply (flags per pending handshake, no FSM copy).
module tb_fp_mul_issuer;
    localparam int TAG_W = 5;
    localparam int CNT_W = 16;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fp_mul_issuer_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    fp_mul_issuer #(.TAG_W(TAG_W), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // model state: what the protocol says is outstanding right now
    bit               m_inflight, m_pa, m_pb, m_wait, m_ack, m_resp, m_to;
    int               m_dwell, m_acc;
    logic [31:0]      m_a, m_b, m_data;
    logic [TAG_W-1:0] m_tag;
    int               m_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                m_inflight = 0; m_pa = 0; m_pb = 0; m_wait = 0; m_ack = 0; m_resp = 0; m_to = 0;
            end else begin
                chk("req_ready", bus.req_ready, !m_inflight);
                chk("busy", bus.busy, m_inflight);
                chk("rsp_valid", bus.rsp_valid, m_resp);
                chk("strb_A", bus.mul_strb_A, m_pa);
                chk("strb_B", bus.mul_strb_B, m_pb);
                chk("prod_ack", bus.mul_prod_ack, m_ack);
                chk("rsp_timeout", bus.rsp_timeout, m_resp ? m_to : 1'b0);
                if (m_pa) chk("in_A", bus.mul_in_A, m_a);
                if (m_pb) chk("in_B", bus.mul_in_B, m_b);
                if (m_resp) begin
                    chk("rsp_data", bus.rsp_data, m_data);
                    chk("rsp_tag", bus.rsp_tag, m_tag);
                    chk("rsp_cycles", bus.rsp_cycles, m_cyc);
                end
                // advance the model across the coming edge
                if (m_resp) begin
                    if (bus.rsp_ready) begin m_resp = 0; m_inflight = 0; end
                end else if (!m_inflight) begin
                    if (bus.req_valid) begin
                        m_inflight = 1; m_pa = 1; m_pb = 1;
                        m_a = bus.req_a; m_b = bus.req_b; m_tag = bus.req_tag; m_acc = cyc;
                    end
                end else if (m_pa || m_pb) begin
                    if (m_pa && bus.mul_in_A_ack) m_pa = 0;
                    if (m_pb && bus.mul_in_B_ack) m_pb = 0;
                    if (!m_pa && !m_pb) begin m_wait = 1; m_dwell = 0; end
                end else if (m_wait) begin
                    m_dwell++;
                    if (m_dwell == TMO) begin
                        m_wait = 0; m_resp = 1; m_to = 1; m_data = 32'h7FC0_0000;
                        m_cyc = (cyc - m_acc > 65535) ? 65535 : cyc - m_acc;
                    end else if (bus.mul_prod_stb) begin
                        m_wait = 0; m_ack = 1; m_data = bus.mul_prod;
                    end
                end else if (m_ack) begin
                    if (!bus.mul_prod_stb) begin
                        m_ack = 0; m_resp = 1; m_to = 0;
                        m_cyc = (cyc - m_acc > 65535) ? 65535 : cyc - m_acc;
                    end
                end
            end
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_req_ready"}, bus.req_ready, 1'b1);
        chk({p, "_busy"}, bus.busy, 1'b0);
        chk({p, "_strb_A"}, bus.mul_strb_A, 1'b0);
        chk({p, "_strb_B"}, bus.mul_strb_B, 1'b0);
        chk({p, "_prod_ack"}, bus.mul_prod_ack, 1'b0);
        chk({p, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        chk({p, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
        chk({p, "_in_A"}, bus.mul_in_A, 32'h0);
        chk({p, "_in_B"}, bus.mul_in_B, 32'h0);
        chk({p, "_rsp_data"}, bus.rsp_data, 32'h0);
        chk({p, "_rsp_tag"}, bus.rsp_tag, 32'h0);
        chk({p, "_rsp_cycles"}, bus.rsp_cycles, 32'h0);
    endtask

    // one full operation; entered and left at posedge+1
    task automatic run_op(
        input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
        input int da, input int db, input int dp, input int hold, input int rdy,
        input bit no_prod, input logic [31:0] prod,
        input bit early, input logic [31:0] na, input logic [31:0] nb, input logic [TAG_W-1:0] ntag,
        output logic [31:0] o_data, output logic [TAG_W-1:0] o_tag,
        output logic o_to, output logic [CNT_W-1:0] o_cyc);
        bit ok;
        o_data = '0; o_tag = '0; o_to = 1'b0; o_cyc = '0;
        bus.req_a = a; bus.req_b = b; bus.req_tag = tag; bus.req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1;
        end
        chk("accept_wait", ok, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        fork
            begin
                repeat (da) begin @(posedge clk); #1; end
                bus.mul_in_A_ack = 1'b1; @(posedge clk); #1; bus.mul_in_A_ack = 1'b0;
            end
            begin
                repeat (db) begin @(posedge clk); #1; end
                bus.mul_in_B_ack = 1'b1; @(posedge clk); #1; bus.mul_in_B_ack = 1'b0;
            end
        join
        if (!no_prod) begin
            repeat (dp) begin @(posedge clk); #1; end
            bus.mul_prod = prod; bus.mul_prod_stb = 1'b1;
            ok = 0;
            for (int i = 0; i < TMO + 6 && !ok; i++) begin
                @(posedge clk); #1;
                if (bus.mul_prod_ack || bus.rsp_valid) ok = 1;
            end
            chk("prod_ack_wait", ok, 1'b1);
            if (bus.mul_prod_ack) repeat (hold) begin @(posedge clk); #1; end
            bus.mul_prod_stb = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (bus.rsp_valid) ok = 1;
            else begin @(posedge clk); #1; end
        end
        chk("rsp_wait", ok, 1'b1);
        o_data = bus.rsp_data; o_tag = bus.rsp_tag; o_to = bus.rsp_timeout; o_cyc = bus.rsp_cycles;
        if (early) begin
            bus.req_a = na; bus.req_b = nb; bus.req_tag = ntag; bus.req_valid = 1'b1;
        end
        repeat (rdy) begin
            chk("bp_req_ready", bus.req_ready, 1'b0);
            @(posedge clk); #1;
            chk("bp_rsp_data_stable", bus.rsp_data, o_data);
            chk("bp_rsp_cycles_stable", bus.rsp_cycles, o_cyc);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0]      od;
        logic [TAG_W-1:0] ot;
        logic             oto;
        logic [CNT_W-1:0] oc;
        logic [31:0]      ra, rb, rp;

        bus.req_valid = 0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.mul_in_A_ack = 0; bus.mul_in_B_ack = 0; bus.mul_prod = '0; bus.mul_prod_stb = 0;
        bus.rsp_ready = 0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // nominal 1.5 * 2.0
        run_op(32'h3FC0_0000, 32'h4000_0000, 5'd3, 1, 1, 5, 0, 0, 0, 32'h4040_0000,
               0, '0, '0, '0, od, ot, oto, oc);
        chk("nom_data", od, 32'h4040_0000);
        chk("nom_tag", ot, 32'd3);
        chk("nom_timeout", oto, 1'b0);

        // minimum latency: acks one cycle after strobe, immediate product
        run_op(32'h1111_1111, 32'h2222_2222, 5'd7, 1, 1, 0, 0, 0, 0, 32'hABCD_0123,
               0, '0, '0, '0, od, ot, oto, oc);
        chk("minlat_cycles", oc, 32'd4);

        // skewed acks
        run_op(32'hC0A0_0000, 32'h3F80_0000, 5'd12, 1, 7, 2, 0, 1, 0, 32'hC0A0_0000,
               0, '0, '0, '0, od, ot, oto, oc);
        chk("skew_data", od, 32'hC0A0_0000);

        // timeout: no product ever
        run_op(32'h4100_0000, 32'h4200_0000, 5'd9, 0, 0, 0, 0, 0, 1, 32'h0,
               0, '0, '0, '0, od, ot, oto, oc);
        chk("tmo_data", od, 32'h7FC0_0000);
        chk("tmo_flag", oto, 1'b1);
        chk("tmo_cycles", oc, 32'd9);

        // product on the last WAIT cycle loses; one cycle earlier wins
        run_op(32'h1, 32'h2, 5'd1, 0, 0, 7, 0, 0, 0, 32'h1234_5678,
               0, '0, '0, '0, od, ot, oto, oc);
        chk("edge_tmo_flag", oto, 1'b1);
        run_op(32'h3, 32'h4, 5'd2, 0, 0, 6, 0, 0, 0, 32'h1234_5678,
               0, '0, '0, '0, od, ot, oto, oc);
        chk("edge_ok_flag", oto, 1'b0);
        chk("edge_ok_data", od, 32'h1234_5678);

        // backpressure with a second request waiting
        run_op(32'h5555_0000, 32'h6666_0000, 5'd20, 2, 1, 3, 0, 10, 0, 32'h7777_0000,
               1, 32'h8888_0000, 32'h9999_0000, 5'd21, od, ot, oto, oc);
        chk("bp_data", od, 32'h7777_0000);
        run_op(32'h8888_0000, 32'h9999_0000, 5'd21, 0, 0, 1, 0, 0, 0, 32'hAAAA_0000,
               0, '0, '0, '0, od, ot, oto, oc);
        chk("bp2_tag", ot, 32'd21);

        // slow product release
        run_op(32'hBF80_0000, 32'hBF80_0000, 5'd31, 1, 1, 1, 4, 0, 0, 32'h3F80_0000,
               0, '0, '0, '0, od, ot, oto, oc);
        chk("slow_data", od, 32'h3F80_0000);

        // acks with no strobe outstanding are ignored
        bus.mul_in_A_ack = 1; bus.mul_in_B_ack = 1;
        @(posedge clk); #1;
        bus.mul_in_A_ack = 0; bus.mul_in_B_ack = 0;
        @(posedge clk); #1;

        // reset in the middle of WAIT
        bus.req_a = 32'hDEAD_BEEF; bus.req_b = 32'hCAFE_F00D; bus.req_tag = 5'd17; bus.req_valid = 1;
        @(posedge clk); #1;
        bus.req_valid = 0;
        bus.mul_in_A_ack = 1; bus.mul_in_B_ack = 1;
        @(posedge clk); #1;
        bus.mul_in_A_ack = 0; bus.mul_in_B_ack = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_busy", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        run_op(32'h3FC0_0000, 32'h4000_0000, 5'd3, 1, 1, 5, 0, 0, 0, 32'h4040_0000,
               0, '0, '0, '0, od, ot, oto, oc);
        chk("post_rst_data", od, 32'h4040_0000);
        chk("post_rst_cycles", oc, 32'd9);

        // randomised traffic
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rp = $urandom;
            run_op(ra, rb, TAG_W'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 10)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0), rp, 0, '0, '0, '0, od, ot, oto, oc);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
